// File: rtl/mul_share_pkg.sv
// Shared types and the round-robin pick helper for the shared multiplier.
package mul_share_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_WS   = 16;
    localparam int DEF_LAT  = 2;
    localparam int NREQ_MAX = 8;

    typedef struct packed {
        logic                        vld;
        logic [$clog2(DEF_NREQ)-1:0] id;
        logic [DEF_WS-1:0]           a;
        logic [DEF_WS-1:0]           b;
    } stage_t;

    // One-hot grant of the first set bit after 'last', wrapping modulo n.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input int                  n,
        input int                  last
    );
        logic [NREQ_MAX-1:0] g;
        int                  idx;
        g = '0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            idx = (last + k) % n;
            if (k <= n && g == '0 && req[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/mul_share_pipe.sv
// LAT-deep unsigned multiplier pipe carrying a valid/id sideband; hold freezes it.
// Exposes stage valids only when MUL_SHARE_ARB_ASSERT_EN is defined.
module mul_share_pipe
    import mul_share_pkg::*;
#(
    parameter int IW  = 2,
    parameter int WS  = DEF_WS,
    parameter int WL  = 32,
    parameter int LAT = DEF_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          in_vld,
    input  logic [IW-1:0] in_id,
    input  logic [WS-1:0] in_a,
    input  logic [WS-1:0] in_b,
    output logic          out_vld,
    output logic [IW-1:0] out_id,
`ifdef MUL_SHARE_ARB_ASSERT_EN
    output logic [LAT-1:0] stage_vld,
`endif
    output logic [WL-1:0] out_data
);

    logic [LAT-1:0] vld;
    logic [IW-1:0]  id [LAT];
    logic [WL-1:0]  p  [LAT];

    // Products only move with a valid op, so the last stage keeps the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                id[k] <= '0;
                p[k]  <= '0;
            end
        end else if (!hold) begin
            vld[0] <= in_vld;
            id[0]  <= in_id;
            if (in_vld) p[0] <= WL'(in_a) * WL'(in_b);
            for (int k = 1; k < LAT; k++) begin
                vld[k] <= vld[k-1];
                id[k]  <= id[k-1];
                if (vld[k-1]) p[k] <= p[k-1];
            end
        end
    end

    assign out_vld  = vld[LAT-1];
    assign out_id   = id[LAT-1];
    assign out_data = p[LAT-1];

`ifdef MUL_SHARE_ARB_ASSERT_EN
    assign stage_vld = vld;
`endif

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin front end sharing one pipelined multiplier among NREQ requesters.
// Define MUL_SHARE_ARB_ASSERT_EN to elaborate embedded checks and a shadow multiplier.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int WS   = DEF_WS,
    parameter int WL   = 32,
    parameter int LAT  = DEF_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WS-1:0]         req_a,
    input  logic [NREQ*WS-1:0]         req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [WL-1:0]              rsp_data,
    output logic [$clog2(LAT+1)-1:0]   inflight,
    output logic                       busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LAT+1);

    logic [IW-1:0]       rr_last;
    logic [IW-1:0]       gid;
    logic [NREQ_MAX-1:0] req_pad;
    logic [NREQ_MAX-1:0] pick;
    logic                issue;
    logic [WS-1:0]       ga;
    logic [WS-1:0]       gb;
    logic                out_vld;
    logic [IW-1:0]       out_id;
`ifdef MUL_SHARE_ARB_ASSERT_EN
    logic [LAT-1:0]      stage_vld;
`endif

    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req_valid;
        pick               = rr_pick(req_pad, NREQ, int'(rr_last));
        req_ready          = hold ? '0 : pick[NREQ-1:0];
        issue              = !hold && (|pick);
        gid                = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) gid = IW'(i);
        end
        ga = req_a[gid*WS +: WS];
        gb = req_b[gid*WS +: WS];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last  <= IW'(NREQ-1);
            inflight <= '0;
        end else if (!hold) begin
            if (issue) rr_last <= gid;
            inflight <= inflight + CW'(issue) - CW'(out_vld);
        end
    end

    mul_share_pipe #(
        .IW  (IW),
        .WS  (WS),
        .WL  (WL),
        .LAT (LAT)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .in_vld   (issue),
        .in_id    (gid),
        .in_a     (ga),
        .in_b     (gb),
        .out_vld  (out_vld),
        .out_id   (out_id),
`ifdef MUL_SHARE_ARB_ASSERT_EN
        .stage_vld(stage_vld),
`endif
        .out_data (rsp_data)
    );

    always_comb begin
        rsp_valid = '0;
        if (out_vld && !hold) rsp_valid[out_id] = 1'b1;
    end

    assign busy = (inflight != '0);

`ifdef MUL_SHARE_ARB_ASSERT_EN
    logic [WL-1:0] sh [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) sh[k] <= '0;
        end else if (!hold) begin
            sh[0] <= issue ? (WL'(ga) * WL'(gb)) : '0;
            for (int k = 1; k < LAT; k++) sh[k] <= sh[k-1];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready));
            assert ($onehot0(rsp_valid));
            assert (int'(inflight) <= LAT);
            assert (int'(inflight) == $countones(stage_vld));
            assert ((req_ready & ~req_valid) == '0);
            assert (rsp_valid == '0 || sh[LAT-1] == rsp_data);
        end
    end
`endif

endmodule
